// File: rtl/trig_pkg.sv
// trig_pkg: shared types and defaults for the trigger capture block.
//   cap_state_t          - capture FSM states
//   CAP_CNT_W_DEFAULT    - default cycle counter width
//   CAP_TIMEOUT_DEFAULT  - default ARMED timeout in cycles
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLD
  } cap_state_t;

  localparam int unsigned CAP_CNT_W_DEFAULT   = 8;
  localparam int unsigned CAP_TIMEOUT_DEFAULT = 200;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registers a single-bit line and flags its rising edge.
//   clk  - clock
//   rst  - asynchronous active-high reset (q cleared to 0)
//   din  - line to watch
//   q    - din delayed by one cycle
//   rise - combinational din & ~q
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= din;
  end

  assign rise = din & ~q;

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: arms on request, counts cycles until a rising edge on
// trigger (or TIMEOUT cycles), then presents the result on a valid/ready port.
//   clk         - clock
//   rst         - asynchronous active-high reset
//   arm         - start a measurement (IDLE, or HOLD together with out_ready)
//   trigger     - event line; only rising edges count
//   out_ready   - consumer accepts the result
//   busy        - high in ARMED or HOLD
//   trig_edge   - combinational: qualified rising edge while ARMED
//   out_valid   - result available (registered)
//   out_count   - latency in cycles from first ARMED cycle, or TIMEOUT
//   out_timeout - result is a timeout rather than an edge
module trigger_capture
  import trig_pkg::*;
#(
  parameter int unsigned CNT_W   = CAP_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = CAP_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             trigger,
  input  logic             out_ready,
  output logic             busy,
  output logic             trig_edge,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_timeout
);

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             valid_d, timeout_d;
  logic [CNT_W-1:0] count_d;
  logic             trig_q;
  logic             trig_rise;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (trigger),
    .q    (trig_q),
    .rise (trig_rise)
  );

  assign trig_edge = (state == ST_ARMED) & trig_rise;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    valid_d   = out_valid;
    count_d   = out_count;
    timeout_d = out_timeout;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Edge wins over a coincident timeout.
        if (trig_edge) begin
          state_d   = ST_HOLD;
          count_d   = cnt;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          cnt_d     = '0;
        end else if (cnt == TO_VAL) begin
          state_d   = ST_HOLD;
          count_d   = TO_VAL;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = arm ? ST_ARMED : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      out_valid   <= valid_d;
      out_count   <= count_d;
      out_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed, table-driven bench for trigger_capture.
// Main DUT uses TIMEOUT=10; a second instance with TIMEOUT=4 covers the
// edge/timeout coincidence.
module tb_trigger_capture;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm, trg, rdy;
  logic         busy, tedge, valid, tmo;
  logic [W-1:0] count;
  logic         arm4, trg4, rdy4;
  logic         busy4, tedge4, valid4, tmo4;
  logic [W-1:0] count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trigger_capture #(.CNT_W(W), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger(trg), .out_ready(rdy),
    .busy(busy), .trig_edge(tedge), .out_valid(valid),
    .out_count(count), .out_timeout(tmo)
  );

  trigger_capture #(.CNT_W(W), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .arm(arm4), .trigger(trg4), .out_ready(rdy4),
    .busy(busy4), .trig_edge(tedge4), .out_valid(valid4),
    .out_count(count4), .out_timeout(tmo4)
  );

  typedef struct {
    logic         arm, trg, rdy;
    logic         busy, edg, valid, tmo;
    logic [W-1:0] cnt;
  } vec_t;

  vec_t tbl [11];

  // {busy, trig_edge, out_valid, out_timeout, out_count}
  function automatic logic [11:0] pk(logic b, logic e, logic v, logic t, logic [W-1:0] c);
    return {b, e, v, t, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic a, input logic t, input logic r);
    arm = a; trg = t; rdy = r;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tseq [6];
    logic eseq [6];

    tbl[0]  = '{0,0,0, 0,0,0,0, 8'd0};
    tbl[1]  = '{1,0,0, 0,0,0,0, 8'd0};
    tbl[2]  = '{0,0,0, 1,0,0,0, 8'd0};
    tbl[3]  = '{0,0,0, 1,0,0,0, 8'd0};
    tbl[4]  = '{0,0,0, 1,0,0,0, 8'd0};
    tbl[5]  = '{0,0,0, 1,0,0,0, 8'd0};
    tbl[6]  = '{0,0,0, 1,0,0,0, 8'd0};
    tbl[7]  = '{0,1,0, 1,1,0,0, 8'd0};
    tbl[8]  = '{0,1,0, 1,0,1,0, 8'd5};
    tbl[9]  = '{0,1,1, 1,0,1,0, 8'd5};
    tbl[10] = '{0,0,0, 0,0,0,0, 8'd5};

    arm = 0; trg = 0; rdy = 0;
    arm4 = 0; trg4 = 0; rdy4 = 0;
    rst = 1;
    repeat (3) step;
    chk("reset", pk(busy, tedge, valid, tmo, count), pk(0,0,0,0,8'd0));
    rst = 0;

    // Basic measurement: edge 5 cycles after first ARMED cycle.
    for (int unsigned i = 0; i < 11; i++) begin
      apply(tbl[i].arm, tbl[i].trg, tbl[i].rdy);
      chk($sformatf("basic[%0d]", i), pk(busy, tedge, valid, tmo, count),
          pk(tbl[i].busy, tbl[i].edg, tbl[i].valid, tbl[i].tmo, tbl[i].cnt));
      step;
    end

    // Timeout: 11 ARMED cycles with trigger low.
    apply(1, 0, 0); step;
    for (int unsigned i = 0; i < 11; i++) begin
      apply(0, 0, 0);
      chk($sformatf("to_wait[%0d]", i), {30'd0, busy, valid}, 32'd2);
      step;
    end
    apply(0, 0, 0);
    chk("timeout", pk(busy, tedge, valid, tmo, count), pk(1,0,1,1,8'd10));
    apply(0, 0, 1); step;
    apply(0, 0, 0);
    chk("to_ack", {31'd0, busy}, 32'd0);

    // Trigger already high at arm: wait for low then high.
    apply(0, 1, 0); step;
    apply(1, 1, 0); step;
    tseq = '{1, 1, 1, 0, 0, 1};
    eseq = '{0, 0, 0, 0, 0, 1};
    for (int unsigned i = 0; i < 6; i++) begin
      apply(0, tseq[i], 0);
      chk($sformatf("prehigh_edge[%0d]", i), {31'd0, tedge}, {31'd0, eseq[i]});
      step;
    end
    apply(0, 1, 0);
    chk("prehigh", pk(busy, tedge, valid, tmo, count), pk(1,0,1,0,8'd5));

    // Hold with out_ready low: trigger toggles, arm pulses, nothing moves.
    for (int unsigned i = 0; i < 4; i++) begin
      apply((i == 1 || i == 3), (i % 2 == 0), 0);
      chk($sformatf("hold[%0d]", i), pk(busy, tedge, valid, tmo, count), pk(1,0,1,0,8'd5));
      step;
    end
    // Back-to-back re-arm.
    apply(1, 0, 1);
    chk("b2b_hs", pk(busy, tedge, valid, tmo, count), pk(1,0,1,0,8'd5));
    step;
    apply(0, 0, 0);
    chk("b2b_armed", pk(busy, tedge, valid, tmo, count), pk(1,0,0,0,8'd5));
    step;
    apply(0, 0, 0); step;
    apply(0, 1, 0);
    chk("b2b_edge", {31'd0, tedge}, 32'd1);
    step;
    chk("b2b_result", pk(busy, tedge, valid, tmo, count), pk(1,0,1,0,8'd2));
    apply(0, 0, 1); step;

    // Asynchronous reset mid-ARMED.
    apply(1, 0, 0); step;
    apply(0, 0, 0); step;
    step;
    #2 rst = 1;
    #1;
    chk("async_rst", pk(busy, tedge, valid, tmo, count), pk(0,0,0,0,8'd0));
    step;
    rst = 0;
    apply(1, 0, 0); step;
    apply(0, 0, 0); step;
    apply(0, 1, 0);
    chk("post_rst_edge", {31'd0, tedge}, 32'd1);
    step;
    chk("post_rst", pk(busy, tedge, valid, tmo, count), pk(1,0,1,0,8'd1));

    // Edge coincides with cnt==TIMEOUT on the TIMEOUT=4 instance.
    arm4 = 1; #1; step;
    arm4 = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("coinc_wait[%0d]", i), {30'd0, busy4, valid4}, 32'd2);
      step;
    end
    trg4 = 1; #1;
    chk("coinc_edge", {31'd0, tedge4}, 32'd1);
    step;
    chk("coinc", pk(busy4, tedge4, valid4, tmo4, count4), pk(1,0,1,0,8'd4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
